// File: rtl/regbank_seq_8088.sv
`default_nettype none
// ============================================================================
// Module   : regbank_seq_8088
// Brief    : 8086-style MOV / XCHG / MOVI sequencer driving an external
//            register bank (two combinational read ports, one write port).
// Revision : 1.0 - initial release
// ============================================================================
module regbank_seq_8088 (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_w,
    input  logic [2:0]  cmd_dst,
    input  logic [2:0]  cmd_src,
    input  logic [15:0] cmd_imm,
    output logic        rb_en_write,
    output logic        rb_size,
    output logic        rb_select_high_low,
    output logic [2:0]  rb_reg_write,
    output logic [2:0]  rb_reg_read1,
    output logic [2:0]  rb_reg_read2,
    output logic [15:0] rb_write_data,
    input  logic [15:0] rb_read_data1,
    input  logic [15:0] rb_read_data2,
    output logic        done,
    output logic        err,
    output logic [15:0] result
);

    // Sequencer states
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WR1  = 3'd2;
    localparam logic [2:0] WR2  = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    // Operation codes
    localparam logic [1:0] c_op_mov  = 2'b00;
    localparam logic [1:0] c_op_xchg = 2'b01;
    localparam logic [1:0] c_op_movi = 2'b10;

    // 8086 register code -> bank index. The bank stores AX,BX,CX,DX in
    // slots 0..3 while the ISA encodes AX,CX,DX,BX; codes 4..7 of 16-bit
    // operands address SP,BP,SI,DI directly. 8-bit codes use only [1:0].
    function automatic logic [2:0] f_bank_idx(input logic [2:0] code, input logic w);
        logic [2:0] idx;
        case (code[1:0])
            2'd0:    idx = 3'd0;
            2'd1:    idx = 3'd2;
            2'd2:    idx = 3'd3;
            default: idx = 3'd1;
        endcase
        if (w && code[2]) begin
            idx = code;
        end
        return idx;
    endfunction

    // Byte lane of an 8-bit operand: codes 4..7 are the high bytes (AH..BH)
    function automatic logic f_bank_sel(input logic [2:0] code, input logic w);
        return !w && code[2];
    endfunction

    // Operand value as seen by the instruction, zero-extended for byte ops
    function automatic logic [15:0] f_extract(input logic [15:0] data, input logic [2:0] code,
                                              input logic w);
        if (w) begin
            return data;
        end
        return code[2] ? {8'h00, data[15:8]} : {8'h00, data[7:0]};
    endfunction

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [1:0]  r_op;
    logic        r_w;
    logic [2:0]  r_dst;
    logic [2:0]  r_src;
    logic [15:0] r_imm;
    logic [15:0] r_src_val;
    logic [15:0] r_dst_val;
    logic [15:0] r_result;

    logic [2:0]  w_dst_idx;
    logic [2:0]  w_src_idx;
    logic        w_dst_sel;
    logic        w_src_sel;
    logic [15:0] w_wr1_data;

    assign w_dst_idx    = f_bank_idx(r_dst, r_w);
    assign w_src_idx    = f_bank_idx(r_src, r_w);
    assign w_dst_sel    = f_bank_sel(r_dst, r_w);
    assign w_src_sel    = f_bank_sel(r_src, r_w);
    assign w_wr1_data   = (r_op == c_op_movi) ? (r_w ? r_imm : {8'h00, r_imm[7:0]}) : r_src_val;

    assign rb_reg_read1 = w_src_idx;
    assign rb_reg_read2 = w_dst_idx;
    assign result       = r_result;

    // State register; reset aborts any command in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and bank/handshake outputs
    always_comb begin
        w_state_nxt        = r_state;
        cmd_ready          = 1'b0;
        rb_en_write        = 1'b0;
        rb_size            = r_w;
        rb_select_high_low = 1'b0;
        rb_reg_write       = w_dst_idx;
        rb_write_data      = w_wr1_data;
        done               = 1'b0;
        err                = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        c_op_mov, c_op_xchg: w_state_nxt = RD;
                        c_op_movi:           w_state_nxt = WR1;
                        default:             w_state_nxt = FIN;
                    endcase
                end
            end
            RD: begin
                w_state_nxt = WR1;
            end
            WR1: begin
                rb_en_write        = 1'b1;
                rb_select_high_low = w_dst_sel;
                w_state_nxt        = (r_op == c_op_xchg) ? WR2 : FIN;
            end
            WR2: begin
                rb_en_write        = 1'b1;
                rb_reg_write       = w_src_idx;
                rb_write_data      = r_dst_val;
                rb_select_high_low = w_src_sel;
                w_state_nxt        = FIN;
            end
            FIN: begin
                done        = 1'b1;
                err         = (r_op == 2'b11);
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Capture the command on acceptance; later cmd_* activity is ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op  <= 2'b00;
            r_w   <= 1'b0;
            r_dst <= 3'd0;
            r_src <= 3'd0;
            r_imm <= 16'h0000;
        end else if (cmd_valid && cmd_ready) begin
            r_op  <= cmd_op;
            r_w   <= cmd_w;
            r_dst <= cmd_dst;
            r_src <= cmd_src;
            r_imm <= cmd_imm;
        end
    end

    // Snapshot both operands in RD so the XCHG second write sees the old dst
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src_val <= 16'h0000;
            r_dst_val <= 16'h0000;
        end else if (r_state == RD) begin
            r_src_val <= f_extract(rb_read_data1, r_src, r_w);
            r_dst_val <= f_extract(rb_read_data2, r_dst, r_w);
        end
    end

    // Result tracks the dst write so it is already valid while done is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= 16'h0000;
        end else if (r_state == WR1) begin
            r_result <= w_wr1_data;
        end
    end

endmodule
`default_nettype wire

// File: doc/regbank_seq_8088.md
REGBANK_SEQ_8088 -- requirements
Module: regbank_seq_8088

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  block idle and able to accept a command.
REQ-006 cmd_op  in  2  operation: 00 MOV, 01 XCHG, 10 MOVI, 11 illegal.
REQ-007 cmd_w  in  1  operand size: 0 is 8 bits, 1 is 16 bits.
REQ-008 cmd_dst, cmd_src  in  3 each  8086 register codes (16-bit: AX,CX,DX,BX,SP,BP,SI,DI; 8-bit: AL,CL,DL,BL,AH,CH,DH,BH).
REQ-009 cmd_imm  in  16  MOVI immediate; only bits [7:0] are used when cmd_w=0.
REQ-010 rb_en_write, rb_size, rb_select_high_low  out  1 each  register-bank write enable, size and high/low byte select.
REQ-011 rb_reg_write, rb_reg_read1, rb_reg_read2  out  3 each  bank indices.
REQ-012 rb_write_data  out  16  bank write data.
REQ-013 rb_read_data1, rb_read_data2  in  16 each  bank read data, combinational from the rb_reg_read indices.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 err  out  1  qualifies done; set only for the illegal op.
REQ-016 result  out  16  value written to dst; upper byte is zero for 8-bit operations.

Function
REQ-017 Code-to-bank index map SHALL be: 0->0, 1->2, 2->3, 3->1, 4..7 unchanged (16-bit); for 8-bit operands: index = map(code[1:0]), select_high_low = code[2].
REQ-018 The FSM states SHALL be IDLE, RD, WR1, WR2, FIN; cmd_ready = (state==IDLE).
REQ-019 A command SHALL be accepted when cmd_valid and cmd_ready are both high; all cmd_* fields are latched on acceptance.
REQ-020 Transitions on acceptance: MOV and XCHG go IDLE->RD; MOVI goes IDLE->WR1; illegal goes IDLE->FIN.
REQ-021 In RD: rb_reg_read1 = src index, rb_reg_read2 = dst index; both read values are latched, byte-extracted for 8-bit (select=1 takes [15:8], else [7:0]).
REQ-022 Transition RD->WR1 SHALL be unconditional.
REQ-023 In WR1: rb_en_write=1, rb_reg_write = dst index, rb_write_data = src value (MOV/XCHG) or immediate (MOVI), rb_size = cmd_w, rb_select_high_low from dst.
REQ-024 After WR1: XCHG goes to WR2; all other ops go to FIN.
REQ-025 In WR2: write the latched dst value into src (select from src); then go to FIN.
REQ-026 FIN SHALL pulse done for exactly one cycle (err=1 only for illegal op), update result (unchanged when err=1), then return to IDLE.
REQ-027 Latency from acceptance edge to done: MOVI 2, MOV 3, XCHG 4, illegal 1 cycle.
REQ-028 rb_en_write SHALL be 0 in every state except WR1 and WR2; the illegal op SHALL never write.
REQ-029 8-bit write data SHALL be {8'h00, byte}.
REQ-030 XCHG with dst==src SHALL execute both writes and leave the register unchanged.
REQ-031 cmd_valid while not ready SHALL be ignored and SHALL NOT alter the command in flight.

Reset
REQ-032 While reset is high: state=IDLE, cmd_ready=1, done=0, err=0, result=16'h0000, rb_en_write=0, all latched operands 0.
REQ-033 Reset asserted mid-command SHALL abort it immediately, with no further bank writes and no done pulse.

Verification
REQ-034 MOVI w=1 dst=3(BX) imm=16'h1234 -> bank write index 1 with 16'h1234; done 2 cycles after acceptance; result=16'h1234.
REQ-035 With AX=16'hAB00, MOV w=0 dst=1(CL) src=4(AH) -> write bank index 2, select=0, data 16'h00AB; result=16'h00AB; done after 3 cycles.
REQ-036 With AX=16'h1111 and SI=16'h2222, XCHG w=1 dst=0 src=6 -> WR1 writes index 0 with 2222; WR2 writes index 6 with 1111; done after 4 cycles.
REQ-037 cmd_op=11 -> done and err in the same cycle, 1 cycle after acceptance; zero bank writes; result unchanged.
REQ-038 Reset pulse during WR1 of an XCHG -> no WR2 write, no done; cmd_ready=1 after reset.
REQ-039 Back-to-back cmd_valid held high -> second command accepted only in the IDLE cycle after FIN; no command lost or duplicated.
